branch_ctrl: RTL and testbench

- Control-side partner of the instruction fetch unit; decides redirection of the program counter.
- Takes the decoded branch class of the current instruction plus the current ProgCtr. Produces the relative-branch enable, the take flag, and the sign-extended relative Target that fetch adds to ProgCtr.
- Adds subroutine support via a return-address stack, so call/return map onto fetch's relative-branch mechanism.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/branch_ctrl_ras_stack.sv | 54 +++++
 rtl/branch_ctrl.sv | 129 ++++++++++++
 tb/tb_branch_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch controller: op encoding, branch offset table, sign-extend helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package branch_pkg;

    localparam int LUTW_DEF = 4;
    localparam int LUT_N    = 2 ** LUTW_DEF;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_BR   = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    // Relative branch offsets selected by the decoder's LUT index.
    localparam logic signed [7:0] BR_LUT [LUT_N] = '{
        8'sd4,    8'sd16,   -8'sd2,   -8'sd5,
        8'sd60,   8'sd127,  -8'sd128, 8'sd1,
        -8'sd1,   8'sd32,   -8'sd32,  8'sd100,
        -8'sd100, 8'sd8,    -8'sd16,  8'sd0
    };

    // Sign-extend an 8-bit offset; callers keep the low PC-width bits.
    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

endpackage

// File: rtl/branch_ctrl_ras_stack.sv
// Return-address LIFO: push drops when full, pop ignored when empty, no wrap-around.
// Latency: top/depth/full/empty reflect state registered at the previous posedge.
// Backpressure: none; the parent inspects full/empty and never pushes and pops together.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int T     = 12
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [T-1:0]             din,
    output logic [T-1:0]             top,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [T-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_depth;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;

    // Write slot is the current occupancy; top sits one below it (DEPTH is a power of two,
    // so a full stack's low bits are zero and the decrement lands on DEPTH-1).
    assign w_wr_idx  = r_depth[AW-1:0];
    assign w_top_idx = r_depth[AW-1:0] - 1'b1;

    assign full  = (r_depth == (AW+1)'(DEPTH));
    assign empty = (r_depth == '0);
    assign depth = r_depth;
    assign top   = r_mem[w_top_idx];

    // Occupancy counter; contents are don't-care after reset so only the count is cleared.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_depth <= '0;
        end else if (push && !full) begin
            r_depth <= r_depth + 1'b1;
        end else if (pop && !empty) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    // Store a pushed return address unless the stack is already full.
    always_ff @(posedge Clk) begin
        if (!Reset && push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/call/return redirect decision for fetch, with a return-address stack and sticky error flags.
// Latency: outputs combinational from inputs and stack state; stack and flags update at the retiring posedge.
// Backpressure: none; one decision per Valid cycle, Reset/Start override everything.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int T     = 12,
    parameter int DEPTH = 4,
    parameter int LUTW  = LUTW_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Valid,
    input  logic [1:0]             Op,
    input  logic [LUTW-1:0]        LutIdx,
    input  logic                   Cond,
    input  logic [T-1:0]           ProgCtr,
    output logic                   BranchRelEn,
    output logic                   TakeFlag,
    output logic [T-1:0]           Target,
    output logic [$clog2(DEPTH):0] Depth,
    output logic                   Overflow,
    output logic                   Underflow,
    output logic                   RangeErr
);

    logic          w_clr;
    logic          w_act;
    op_e           w_op;
    logic [31:0]   w_lut_sext;
    logic [31:0]   w_diff_sext;
    logic [T:0]    w_diff;
    logic          w_in_range;
    logic [T-1:0]  w_top;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          r_ovf;
    logic          r_unf;
    logic          r_rng;

    assign w_clr = Reset | Start;
    assign w_act = Valid & ~w_clr;
    assign w_op  = op_e'(Op);

    assign w_lut_sext  = sext8(BR_LUT[LutIdx]);

    // Return distance in T+1-bit two's complement; it fits the 8-bit offset when bits T..7 agree.
    assign w_diff      = {1'b0, w_top} - {1'b0, ProgCtr};
    assign w_in_range  = (&w_diff[T:7]) | ~(|w_diff[T:7]);
    assign w_diff_sext = sext8(w_diff[7:0]);

    ras_stack #(
        .DEPTH (DEPTH),
        .T     (T)
    ) u_ras (
        .Clk   (Clk),
        .Reset (w_clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (ProgCtr + 1'b1),
        .top   (w_top),
        .depth (Depth),
        .full  (w_full),
        .empty (w_empty)
    );

    // Decode the op into fetch controls and stack push/pop requests.
    always_comb begin
        BranchRelEn = 1'b0;
        TakeFlag    = 1'b0;
        Target      = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (w_act) begin
            case (w_op)
                OP_BR: begin
                    BranchRelEn = 1'b1;
                    TakeFlag    = Cond;
                    Target      = w_lut_sext[T-1:0];
                end
                OP_CALL: begin
                    BranchRelEn = 1'b1;
                    TakeFlag    = 1'b1;
                    Target      = w_lut_sext[T-1:0];
                    w_push      = 1'b1;
                end
                OP_RET: begin
                    BranchRelEn = 1'b1;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_in_range) begin
                            TakeFlag = 1'b1;
                            Target   = w_diff_sext[T-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky error flags, cleared only by Reset/Start.
    always_ff @(posedge Clk) begin
        if (w_clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_rng <= 1'b0;
        end else if (w_act) begin
            if (w_op == OP_CALL && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_op == OP_RET && w_empty) begin
                r_unf <= 1'b1;
            end
            if (w_op == OP_RET && !w_empty && !w_in_range) begin
                r_rng <= 1'b1;
            end
        end
    end

    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign RangeErr  = r_rng;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios then randomized ops against a queue-based model.
// Latency: checks combinational outputs before each posedge, state #1 after it.
// Backpressure: n/a.
module tb_branch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Start, Valid, Cond;
    logic [1:0]  Op;
    logic [3:0]  LutIdx;
    logic [11:0] ProgCtr;
    logic        BranchRelEn, TakeFlag, Overflow, Underflow, RangeErr;
    logic [11:0] Target;
    logic [2:0]  Depth;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int stk[$];
    bit m_ovf, m_unf, m_rng;
    int ref_lut [16] = '{4, 16, -2, -5, 60, 127, -128, 1, -1, 32, -32, 100, -100, 8, -16, 0};

    always #5 Clk = ~Clk;

    branch_ctrl #(.T(12), .DEPTH(4), .LUTW(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Valid(Valid), .Op(Op),
        .LutIdx(LutIdx), .Cond(Cond), .ProgCtr(ProgCtr),
        .BranchRelEn(BranchRelEn), .TakeFlag(TakeFlag), .Target(Target),
        .Depth(Depth), .Overflow(Overflow), .Underflow(Underflow), .RangeErr(RangeErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction: drive, check decision, clock, update model, check state.
    task automatic step(input bit rst, input bit st, input bit vld, input int op,
                        input int idx, input bit cnd, input int pc);
        int e_en, e_tk, e_tg, diff;
        bit inr;
        @(negedge Clk);
        Reset = rst; Start = st; Valid = vld; Op = 2'(op);
        LutIdx = 4'(idx); Cond = cnd; ProgCtr = 12'(pc);
        #1;
        e_en = 0; e_tk = 0; e_tg = 0; diff = 0; inr = 0;
        if (op == 3 && stk.size() > 0) begin
            diff = stk[$] - pc;
            inr  = (diff >= -128) && (diff <= 127);
        end
        if (!rst && !st && vld) begin
            case (op)
                1: begin e_en = 1; e_tk = cnd; e_tg = ref_lut[idx] & 'hFFF; end
                2: begin e_en = 1; e_tk = 1;   e_tg = ref_lut[idx] & 'hFFF; end
                3: begin
                    e_en = 1;
                    if (inr) begin e_tk = 1; e_tg = diff & 'hFFF; end
                end
                default: ;
            endcase
        end
        chk("BranchRelEn", {31'b0, BranchRelEn}, e_en);
        chk("TakeFlag",    {31'b0, TakeFlag},    e_tk);
        chk("Target",      {20'b0, Target},      e_tg);
        @(posedge Clk);
        if (rst || st) begin
            stk.delete(); m_ovf = 0; m_unf = 0; m_rng = 0;
        end else if (vld && op == 2) begin
            if (stk.size() < 4) stk.push_back((pc + 1) % 4096);
            else m_ovf = 1;
        end else if (vld && op == 3) begin
            if (stk.size() == 0) m_unf = 1;
            else begin
                void'(stk.pop_back());
                if (!inr) m_rng = 1;
            end
        end
        #1;
        chk("Depth",     {29'b0, Depth},     stk.size());
        chk("Overflow",  {31'b0, Overflow},  {31'b0, m_ovf});
        chk("Underflow", {31'b0, Underflow}, {31'b0, m_unf});
        chk("RangeErr",  {31'b0, RangeErr},  {31'b0, m_rng});
    endtask

    initial begin
        int op, pc;
        Reset = 1; Start = 0; Valid = 0; Op = 0; LutIdx = 0; Cond = 0; ProgCtr = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Conditional branch, LUT[3] = -5
        step(0, 0, 1, 1, 3, 1, 100);
        step(0, 0, 1, 1, 3, 0, 100);
        step(0, 0, 0, 1, 3, 1, 100);

        // Call at 40 (+60), return at 105 -> -64
        step(0, 0, 1, 2, 4, 0, 40);
        step(0, 0, 1, 3, 0, 0, 105);

        // Reset mid-sequence after two calls
        step(0, 0, 1, 2, 1, 0, 200);
        step(0, 0, 1, 2, 1, 0, 300);
        step(1, 0, 1, 2, 1, 0, 310);
        step(0, 0, 0, 0, 0, 0, 311);

        // Five calls overflow a 4-deep stack, then drain
        for (int i = 0; i < 5; i++) step(0, 0, 1, 2, 0, 0, 500 + i);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 3, 0, 0, 510);

        // Return on empty stack
        step(0, 0, 1, 3, 0, 0, 7);
        step(0, 0, 1, 0, 0, 0, 8);

        // Out-of-range return, then Start clears the sticky flags
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 10);
        step(0, 0, 1, 3, 0, 0, 300);
        step(0, 1, 1, 2, 0, 0, 301);
        step(0, 0, 0, 0, 0, 0, 302);

        // Randomized ops with returns biased toward the near-range boundary
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 3));
            pc = int'($urandom_range(0, 4095));
            if (op == 3 && stk.size() > 0 && $urandom_range(0, 1) == 1)
                pc = (stk[$] + 4096 + 150 - int'($urandom_range(0, 300))) % 4096;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 7) != 0, op, int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), pc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
